id_ex_reg: RTL and testbench
============================

# id_ex_reg

ID/EX pipeline register for the 5-stage RV32 core: captures decoded control bits, register-file operands, immediate, PC and register addresses at the end of ID and presents them to EX one cycle later. It contains the load-use hazard detector. On a hazard it raises a stall to PC/IF-ID and inserts a bubble into EX. It also squashes its contents on a taken-branch flush from later stages.

## Interface
- Parameters:
- `XLEN`, 32, datapath width
- Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  taken branch resolved downstream; squash ID/EX contents
- `instruc_in`  in  32  ID-stage instruction (opcode, rs1, rs2, rd, funct fields)
- `pc_in`  in  XLEN  ID-stage PC
- `rs1_data_in`, `rs2_data_in`  in  XLEN  register-file read data
- `imm_in`  in  XLEN  sign-extended immediate
- `ALUOp_in`  in  2  ALU operation class from control decode
- `ALUSrc_in`, `branch_in`, `mem_read_in`, `mem_write_in`, `reg_write_in`, `mem_to_reg_in`  in  1 each  control decode outputs
- `stall`  out  1  combinational; hold PC and IF/ID this cycle
- `ex_valid`  out  1  EX slot holds a real instruction
- `ex_ALUOp`  out  2; `ex_ALUSrc`, `ex_branch`, `ex_mem_read`, `ex_mem_write`, `ex_reg_write`, `ex_mem_to_reg`  out  1 each  registered control
- `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm`  out  XLEN  registered datapath
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5  registered `instruc_in[19:15]`, `[24:20]`, `[11:7]`
- `ex_funct3`  out  3  registered `instruc_in[14:12]`
- `ex_funct7b5`  out  1  registered `instruc_in[30]`

## Operation
- Register state holds one instruction slot. Each rising edge, the block performs exactly one action, in this priority:
  1. `flush`=1: load a bubble.
  2. `hazard`=1: load a bubble.
  3. Otherwise: load all `*_in` fields and set `ex_valid`=1.
- Bubble: every `ex_*` output is 0, including `ex_valid`, all control bits and all data/address fields.
- Decoded `mem_to_reg_in`=x (for SW and BEQ) is captured as 0. X never propagates.
- Unknown opcodes are captured with all control bits 0 and `ex_valid`=1. A NOP passes through.
- Load-use hazard (combinational):
  - `hazard` = `ex_valid` & `ex_mem_read` & (`ex_rd`≠0) & ((uses_rs1 & `ex_rd`==rs1) | (uses_rs2 & `ex_rd`==rs2)).
  - uses_rs1 applies to opcodes 0110011, 0000011, 0100011, 1100011, 0010011.
  - uses_rs2 applies to opcodes 0110011, 0100011, 1100011.
- `stall` = `hazard` & ~`flush`. A flush overrides the stall, because the instruction in ID is being discarded.
- A load-use stall always lasts exactly one cycle. The inserted bubble has `ex_mem_read`=0, so `hazard` deasserts the next cycle and the held ID instruction then advances.

## Timing
- Latency: 1 cycle from ID inputs to `ex_*` outputs.
- `stall` is valid in the same cycle as `instruc_in`. It depends only on the current inputs and the registered EX state, with no combinational path from `flush` except the masking term.
- Reset (`rst_n`=0, asynchronous): all `ex_*` outputs = 0 immediately. The reset state is a bubble, so `stall`=0.
- Reset released mid-stream: the first edge after release loads normally.
- `flush` and `hazard` in the same cycle: bubble is loaded and `stall`=0.
- Back-to-back loads where the second depends on the first: one stall cycle, then the second load enters EX. If the following instruction depends on the second load, it stalls again.
- rd=x0 never causes a stall, even when the source field is 0.

## Configuration
- `ID_EX_LOAD_USE_STALL_EN`
- Defined: hazard detection and stall are implemented as described above.
- Undefined: `hazard` is tied to 0 and `stall` is constant 0. The register behaves as a plain pipeline register with flush only, and software must schedule around load-use hazards.

## Test plan
- Reset: assert `rst_n`=0 mid-cycle with a valid instruction registered -> all `ex_*`=0 without waiting for a clock edge; `stall`=0.
- Pass-through: `add x3,x1,x2` (0x002081B3) with rs1_data=5, rs2_data=7 -> next cycle: `ex_ALUOp`=10, `ex_reg_write`=1, `ex_rd`=3, `ex_rs1_data`=5, `ex_rs2_data`=7, `ex_valid`=1.
- Load-use: `lw x5,0(x1)` followed by `add x6,x5,x2` -> `stall`=1 for exactly one cycle, one bubble in EX, then the add appears with `ex_rs1`=5.
- No false stall:
  - `lw x0,0(x1)` followed by `add x6,x0,x2` -> `stall`=0.
  - `lw x5,0(x1)` followed by `addi x6,x7,1` -> `stall`=0.
  - `lw x5,...` followed by `addi x6,x1,5` with instruc[24:20]=5 -> `stall`=0, because rs2 is unused.
- Flush priority: `flush`=1 asserted in the same cycle as a load-use hazard -> `stall`=0 and bubble loaded. With the macro undefined, repeat the load-use case -> `stall` stays 0 and the add enters EX immediately.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage RV32 core, with the load-use hazard detector.
// Optional feature: define ID_EX_LOAD_USE_STALL_EN to enable load-use stall; otherwise stall is tied to 0.
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [31:0]     instruc_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [1:0]      ALUOp_in,
    input  logic            ALUSrc_in,
    input  logic            branch_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic            mem_to_reg_in,
    output logic            stall,
    output logic            ex_valid,
    output logic [1:0]      ex_ALUOp,
    output logic            ex_ALUSrc,
    output logic            ex_branch,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5
);

    typedef struct packed {
        logic            valid;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            branch;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            funct7b5;
    } slot_t;

    slot_t slot_d, slot_q;
    logic  hazard;
    logic  unused_instr_bits;

    logic [4:0] id_rs1, id_rs2;
    assign id_rs1 = instruc_in[19:15];
    assign id_rs2 = instruc_in[24:20];

`ifdef ID_EX_LOAD_USE_STALL_EN
    logic [6:0] opcode;
    logic       uses_rs1, uses_rs2;

    assign opcode   = instruc_in[6:0];
    assign uses_rs1 = opcode inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};
    assign uses_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};

    // Only a load still sitting in EX can hazard; its data is not ready until after MEM.
    assign hazard = slot_q.valid & slot_q.mem_read & (slot_q.rd != 5'd0)
                  & ((uses_rs1 & (slot_q.rd == id_rs1)) | (uses_rs2 & (slot_q.rd == id_rs2)));
    assign unused_instr_bits = ^{instruc_in[31], instruc_in[29:25]};
`else
    assign hazard = 1'b0;
    assign unused_instr_bits = ^{instruc_in[31], instruc_in[29:25], instruc_in[6:0]};
`endif

    // The instruction in ID is discarded on a flush, so holding it would be pointless.
    assign stall = hazard & ~flush;

    always_comb begin
        // NOTE: default first so every path assigns slot_d; avoids an inferred latch.
        slot_d = '0;
        if (!flush && !hazard) begin
            slot_d.valid      = 1'b1;
            slot_d.alu_op     = ALUOp_in;
            slot_d.alu_src    = ALUSrc_in;
            slot_d.branch     = branch_in;
            slot_d.mem_read   = mem_read_in;
            slot_d.mem_write  = mem_write_in;
            slot_d.reg_write  = reg_write_in;
            // mem_to_reg is a don't-care for non-writing instructions; gating forces a clean 0.
            slot_d.mem_to_reg = reg_write_in & mem_to_reg_in;
            slot_d.pc         = pc_in;
            slot_d.rs1_data   = rs1_data_in;
            slot_d.rs2_data   = rs2_data_in;
            slot_d.imm        = imm_in;
            slot_d.rs1        = id_rs1;
            slot_d.rs2        = id_rs2;
            slot_d.rd         = instruc_in[11:7];
            slot_d.funct3     = instruc_in[14:12];
            slot_d.funct7b5   = instruc_in[30];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign ex_valid      = slot_q.valid;
    assign ex_ALUOp      = slot_q.alu_op;
    assign ex_ALUSrc     = slot_q.alu_src;
    assign ex_branch     = slot_q.branch;
    assign ex_mem_read   = slot_q.mem_read;
    assign ex_mem_write  = slot_q.mem_write;
    assign ex_reg_write  = slot_q.reg_write;
    assign ex_mem_to_reg = slot_q.mem_to_reg;
    assign ex_pc         = slot_q.pc;
    assign ex_rs1_data   = slot_q.rs1_data;
    assign ex_rs2_data   = slot_q.rs2_data;
    assign ex_imm        = slot_q.imm;
    assign ex_rs1        = slot_q.rs1;
    assign ex_rs2        = slot_q.rs2;
    assign ex_rd         = slot_q.rd;
    assign ex_funct3     = slot_q.funct3;
    assign ex_funct7b5   = slot_q.funct7b5;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; follows ID_EX_LOAD_USE_STALL_EN if defined.
module tb_id_ex_reg;

`ifdef ID_EX_LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam int XLEN = 32;

    // Control bundles: {ALUSrc, branch, mem_read, mem_write, reg_write, mem_to_reg}
    localparam logic [5:0] CTL_R    = 6'b000010;
    localparam logic [5:0] CTL_LOAD = 6'b101011;
    localparam logic [5:0] CTL_IMM  = 6'b100010;
    localparam logic [5:0] CTL_NONE = 6'b000000;

    localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
    localparam logic [31:0] SUB_X3_X1_X2 = 32'h402081B3;
    localparam logic [31:0] SW_X2_4_X1   = 32'h0020A223;
    localparam logic [31:0] LW_X5_0_X1   = 32'h0000A283;
    localparam logic [31:0] LW_X0_0_X1   = 32'h0000A003;
    localparam logic [31:0] LW_X7_0_X5   = 32'h0002A383;
    localparam logic [31:0] ADD_X6_X5_X2 = 32'h00228333;
    localparam logic [31:0] ADD_X6_X0_X2 = 32'h00200333;
    localparam logic [31:0] ADD_X8_X7_X2 = 32'h00238433;
    localparam logic [31:0] ADDI_X6_X7_1 = 32'h00138313;
    localparam logic [31:0] ADDI_X6_X1_5 = 32'h00508313;
    localparam logic [31:0] UNKNOWN_OP   = 32'h0000007F;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush = 1'b0;
    logic [31:0]     instruc_in = '0;
    logic [XLEN-1:0] pc_in = '0, rs1_data_in = '0, rs2_data_in = '0, imm_in = '0;
    logic [1:0]      ALUOp_in = '0;
    logic            ALUSrc_in = 1'b0, branch_in = 1'b0, mem_read_in = 1'b0;
    logic            mem_write_in = 1'b0, reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
    logic            stall, ex_valid;
    logic [1:0]      ex_ALUOp;
    logic            ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;

    int n_checks = 0;
    int n_pass   = 0;

    id_ex_reg #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .instruc_in(instruc_in), .pc_in(pc_in),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in), .imm_in(imm_in),
        .ALUOp_in(ALUOp_in), .ALUSrc_in(ALUSrc_in), .branch_in(branch_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .stall(stall), .ex_valid(ex_valid),
        .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rs1d,
                         input logic [31:0] rs2d, input logic [31:0] imm,
                         input logic [1:0] aluop, input logic [5:0] ctl);
        instruc_in  = ins;
        pc_in       = pc;
        rs1_data_in = rs1d;
        rs2_data_in = rs2d;
        imm_in      = imm;
        ALUOp_in    = aluop;
        {ALUSrc_in, branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in} = ctl;
        #1;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, " valid"}, 64'(ex_valid), 64'd0);
        check({tag, " ctl"}, 64'({ex_ALUOp, ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write,
                                  ex_reg_write, ex_mem_to_reg}), 64'd0);
        check({tag, " data"}, 64'(ex_pc | ex_rs1_data | ex_rs2_data | ex_imm), 64'd0);
        check({tag, " fields"}, 64'({ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5}), 64'd0);
    endtask

    initial begin
        // Asynchronous reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        check_bubble("reset");
        check("reset stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Pass-through of add x3,x1,x2.
        drive(ADD_X3_X1_X2, 32'h100, 32'd5, 32'd7, 32'd0, 2'b10, CTL_R);
        check("add stall", 64'(stall), 64'd0);
        tick();
        check("add valid", 64'(ex_valid), 64'd1);
        check("add aluop", 64'(ex_ALUOp), 64'd2);
        check("add reg_write", 64'(ex_reg_write), 64'd1);
        check("add rd", 64'(ex_rd), 64'd3);
        check("add rs1/rs2", 64'({ex_rs1, ex_rs2}), 64'({5'd1, 5'd2}));
        check("add rs1_data", 64'(ex_rs1_data), 64'd5);
        check("add rs2_data", 64'(ex_rs2_data), 64'd7);
        check("add pc", 64'(ex_pc), 64'h100);
        check("add funct7b5", 64'(ex_funct7b5), 64'd0);

        // funct7 bit 30 and funct3 capture.
        drive(SUB_X3_X1_X2, 32'h104, 32'd9, 32'd4, 32'd0, 2'b10, CTL_R);
        tick();
        check("sub funct7b5", 64'(ex_funct7b5), 64'd1);
        check("sub pc", 64'(ex_pc), 64'h104);

        // Store with mem_to_reg = x must capture 0.
        drive(SW_X2_4_X1, 32'h108, 32'h40, 32'hDEAD, 32'd4, 2'b00, 6'b10010x);
        tick();
        check("sw mem_to_reg", 64'(ex_mem_to_reg), 64'd0);
        check("sw mem_write", 64'(ex_mem_write), 64'd1);
        check("sw imm", 64'(ex_imm), 64'd4);
        check("sw funct3", 64'(ex_funct3), 64'd2);

        // Unknown opcode: valid slot, all control bits 0.
        drive(UNKNOWN_OP, 32'h10C, 32'd1, 32'd2, 32'd3, 2'b00, CTL_NONE);
        tick();
        check("unk valid", 64'(ex_valid), 64'd1);
        check("unk ctl", 64'({ex_ALUOp, ex_ALUSrc, ex_branch, ex_mem_read, ex_mem_write,
                              ex_reg_write, ex_mem_to_reg}), 64'd0);

        // Load-use: lw x5 then add x6,x5,x2.
        drive(LW_X5_0_X1, 32'h200, 32'h80, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        check("lw stall", 64'(stall), 64'd0);
        tick();
        check("lw mem_read", 64'(ex_mem_read), 64'd1);
        check("lw mem_to_reg", 64'(ex_mem_to_reg), 64'd1);
        check("lw rd", 64'(ex_rd), 64'd5);
        drive(ADD_X6_X5_X2, 32'h204, 32'd0, 32'd2, 32'd0, 2'b10, CTL_R);
        check("lu stall", 64'(stall), 64'(STALL_EN));
`ifdef ID_EX_LOAD_USE_STALL_EN
        tick();
        check_bubble("lu bubble");
        check("lu stall released", 64'(stall), 64'd0);
`endif
        tick();
        check("lu add valid", 64'(ex_valid), 64'd1);
        check("lu add rs1", 64'(ex_rs1), 64'd5);
        check("lu add rd", 64'(ex_rd), 64'd6);

        // lw x0 never stalls, even with rs1 = x0.
        drive(LW_X0_0_X1, 32'h300, 32'd0, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        tick();
        drive(ADD_X6_X0_X2, 32'h304, 32'd0, 32'd2, 32'd0, 2'b10, CTL_R);
        check("x0 stall", 64'(stall), 64'd0);
        tick();
        check("x0 add rd", 64'(ex_rd), 64'd6);

        // Independent addi, then addi whose unused rs2 field matches rd.
        drive(LW_X5_0_X1, 32'h400, 32'd0, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        tick();
        drive(ADDI_X6_X7_1, 32'h404, 32'd0, 32'd0, 32'd1, 2'b10, CTL_IMM);
        check("indep stall", 64'(stall), 64'd0);
        drive(LW_X5_0_X1, 32'h408, 32'd0, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        tick();
        drive(ADDI_X6_X1_5, 32'h40C, 32'd0, 32'd0, 32'd5, 2'b10, CTL_IMM);
        check("rs2 unused stall", 64'(stall), 64'd0);
        tick();
        check("addi imm", 64'(ex_imm), 64'd5);

        // Back-to-back dependent loads, then a dependent add.
        drive(LW_X5_0_X1, 32'h500, 32'd0, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        tick();
        drive(LW_X7_0_X5, 32'h504, 32'd0, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        check("b2b stall 1", 64'(stall), 64'(STALL_EN));
`ifdef ID_EX_LOAD_USE_STALL_EN
        tick();
        check("b2b bubble 1", 64'(ex_valid), 64'd0);
`endif
        tick();
        check("b2b lw2 rd", 64'(ex_rd), 64'd7);
        drive(ADD_X8_X7_X2, 32'h508, 32'd0, 32'd0, 32'd0, 2'b10, CTL_R);
        check("b2b stall 2", 64'(stall), 64'(STALL_EN));
`ifdef ID_EX_LOAD_USE_STALL_EN
        tick();
        check("b2b bubble 2", 64'(ex_valid), 64'd0);
`endif
        tick();
        check("b2b add rd", 64'(ex_rd), 64'd8);
        check("b2b add pc", 64'(ex_pc), 64'h508);

        // Flush in the same cycle as a load-use hazard.
        drive(LW_X5_0_X1, 32'h600, 32'd0, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        tick();
        flush = 1'b1;
        drive(ADD_X6_X5_X2, 32'h604, 32'd0, 32'd2, 32'd0, 2'b10, CTL_R);
        check("flush stall", 64'(stall), 64'd0);
        tick();
        flush = 1'b0;
        check_bubble("flush bubble");

        // Mid-cycle asynchronous reset with a valid load in EX and a dependent add in ID.
        drive(LW_X5_0_X1, 32'h700, 32'h11, 32'd0, 32'd0, 2'b00, CTL_LOAD);
        tick();
        drive(ADD_X6_X5_X2, 32'h704, 32'd3, 32'd2, 32'd0, 2'b10, CTL_R);
        check("pre-reset valid", 64'(ex_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_bubble("async reset");
        check("async reset stall", 64'(stall), 64'd0);
        #1 rst_n = 1'b1;
        tick();
        check("post-reset valid", 64'(ex_valid), 64'd1);
        check("post-reset rd", 64'(ex_rd), 64'd6);
        check("post-reset rs1_data", 64'(ex_rs1_data), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
